// File: rtl/tlp_lcrc_framer_if.sv
// tlp_lcrc_framer_if -- stream bundle around the LCRC framer.
//   in_*  : TLP beats from the TX queue (data/valid/sop/eop in, ready back)
//   out_* : framed beats to the replay buffer (data/valid/sop/eop out, ready in)
// Modports:
//   slave  : the framer's view (consumes in_*, produces out_*)
//   master : the surrounding environment's view
interface tlp_lcrc_framer_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_sop;
  logic              in_eop;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_sop;
  logic              out_eop;
  logic              out_ready;

  modport master (
    output in_data, in_valid, in_sop, in_eop,
    input  in_ready,
    input  out_data, out_valid, out_sop, out_eop,
    output out_ready
  );

  modport slave (
    input  in_data, in_valid, in_sop, in_eop,
    output in_ready,
    output out_data, out_valid, out_sop, out_eop,
    input  out_ready
  );
endinterface

// File: rtl/tlp_lcrc_framer.sv
// tlp_lcrc_framer -- wraps each TLP as: header beat (sequence number),
// the TLP beats unchanged, then a trailer beat carrying the LCRC.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : in_* TLP stream, out_* framed stream (single output reg)
//   seq_load      : load next_seq from seq_load_val on the next edge
//   next_seq      : sequence number the next header will carry
//   tlp_done      : pulse in the cycle the trailer is accepted downstream
//   drop_err      : pulse one cycle after a non-sop beat is discarded in IDLE
// Optional feature macro: LCRC_INV_EN -- CRC register starts at all ones and
// the trailer carries the complemented register (PCIe-style LCRC).
module tlp_lcrc_framer #(
  parameter int          DATA_W   = 32,
  parameter int          CRC_W    = 32,
  parameter logic [31:0] CRC_POLY = 32'h04C11DB7,
  parameter int          SEQ_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  tlp_lcrc_framer_if.slave bus,
  input  logic             seq_load,
  input  logic [SEQ_W-1:0] seq_load_val,
  output logic [SEQ_W-1:0] next_seq,
  output logic             tlp_done,
  output logic             drop_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] CRC  = 2'd2;

  localparam logic [CRC_W-1:0] POLY = CRC_POLY[CRC_W-1:0];
`ifdef LCRC_INV_EN
  localparam logic [CRC_W-1:0] INIT   = '1;
  localparam logic [CRC_W-1:0] XOROUT = '1;
`else
  localparam logic [CRC_W-1:0] INIT   = '0;
  localparam logic [CRC_W-1:0] XOROUT = '0;
`endif

  // Whole beat absorbed in one cycle, MSB first, non-reflected.
  function automatic logic [CRC_W-1:0] crc_beat(input logic [CRC_W-1:0] c_in,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = c_in;
    for (int i = DATA_W-1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ d[i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_sop_q, out_sop_d;
  logic              out_eop_q, out_eop_d;
  logic [CRC_W-1:0]  crc_q, crc_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              drop_q, drop_d;
  logic              slot_free;
  logic              done;
  logic              in_ready;
  logic [DATA_W-1:0] hdr;

  assign slot_free = !out_valid_q || bus.out_ready;
  assign done      = out_valid_q && bus.out_ready && out_eop_q;

  // Load beats increment; seq_d is also what a header loaded this cycle
  // carries, so a trailer accepted in the same cycle is already counted.
  assign seq_d = seq_load ? seq_load_val
               : (done ? seq_q + 1'b1 : seq_q);

  assign hdr = DATA_W'(16'(seq_d)) << (DATA_W-16);

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    crc_d       = crc_q;
    drop_d      = 1'b0;
    in_ready    = 1'b0;
    case (state_q)
      IDLE: begin
        // The sop beat is held here; it is taken as data once in DATA.
        in_ready = !bus.in_sop;
        if (bus.in_valid) begin
          if (bus.in_sop) begin
            if (slot_free) begin
              out_data_d  = hdr;
              out_valid_d = 1'b1;
              out_sop_d   = 1'b1;
              out_eop_d   = 1'b0;
              crc_d       = crc_beat(INIT, hdr);
              state_d     = DATA;
            end
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      DATA: begin
        in_ready = slot_free;
        if (bus.in_valid && slot_free) begin
          out_data_d  = bus.in_data;
          out_valid_d = 1'b1;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b0;
          crc_d       = crc_beat(crc_q, bus.in_data);
          if (bus.in_eop) state_d = CRC;
        end
      end
      CRC: begin
        if (slot_free) begin
          out_data_d  = DATA_W'(crc_q ^ XOROUT) << (DATA_W-CRC_W);
          out_valid_d = 1'b1;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      crc_q       <= INIT;
      seq_q       <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      crc_q       <= crc_d;
      seq_q       <= seq_d;
      drop_q      <= drop_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign next_seq      = seq_q;
  assign tlp_done      = done;
  assign drop_err      = drop_q;

endmodule
